// File: rtl/fp_round_pipe_pkg.sv
// Shared FPU rounding types: rounding-mode encoding, exception flag bundle
// and common exponent constants.
package fp_pkg;

  typedef enum logic [2:0] {
    FP_RNE = 3'b000,
    FP_RTZ = 3'b001,
    FP_RDN = 3'b010,
    FP_RUP = 3'b011,
    FP_RMM = 3'b100
  } fp_round_mode_t;

  typedef struct packed {
    logic inexact;
    logic overflow;
  } fp_flags_t;

  localparam int unsigned FP32_EXP_WIDTH = 8;
  localparam int unsigned FP64_EXP_WIDTH = 11;
  localparam logic [FP32_EXP_WIDTH-1:0] FP32_EXP_ALL_ONES = '1;
  localparam logic [FP64_EXP_WIDTH-1:0] FP64_EXP_ALL_ONES = '1;

endpackage

// File: rtl/fp_round_pipe_if.sv
// Valid/ready channels into and out of the rounding pipe.
interface fp_round_pipe_if #(
  parameter int unsigned exp_width  = 8,
  parameter int unsigned frac_width = 23
);
  logic                          in_valid;
  logic                          in_ready;
  logic                          in_sign;
  logic [exp_width-1:0]          in_exp;
  logic [frac_width+2:0]         in_frac;
  logic                          in_special;
  logic [2:0]                    in_mode;
  logic                          out_valid;
  logic                          out_ready;
  logic [exp_width+frac_width:0] out_result;
  logic                          out_inexact;
  logic                          out_overflow;

  modport master (
    output in_valid, in_sign, in_exp, in_frac, in_special, in_mode, out_ready,
    input  in_ready, out_valid, out_result, out_inexact, out_overflow
  );

  modport slave (
    input  in_valid, in_sign, in_exp, in_frac, in_special, in_mode, out_ready,
    output in_ready, out_valid, out_result, out_inexact, out_overflow
  );
endinterface

// File: rtl/fp_round_pipe_decide.sv
// Combinational round-up decision from mode, sign and the L/G/R/S bits.
module fp_round_decide
  import fp_pkg::*;
(
  input  logic [2:0] mode,
  input  logic       sign,
  input  logic       lsb,
  input  logic       guard,
  input  logic       round,
  input  logic       sticky,
  output logic       round_up
);
  logic any_rem;

  always_comb begin
    any_rem  = guard | round | sticky;
    round_up = 1'b0;
    case (mode)
      FP_RTZ:  round_up = 1'b0;
      FP_RDN:  round_up = sign & any_rem;
      FP_RUP:  round_up = ~sign & any_rem;
      FP_RMM:  round_up = guard;
      // Unassigned encodings fall back to round-to-nearest-even.
      default: round_up = guard & (lsb | round | sticky);
    endcase
  end
endmodule

// File: rtl/fp_round_pipe.sv
// Two-stage IEEE-754 rounding pipe: S1 latches operands with the round-up
// decision, S2 applies the increment, overflow/special handling and flags.
module fp_round_pipe
  import fp_pkg::*;
#(
  parameter int unsigned exp_width  = 8,
  parameter int unsigned frac_width = 23
) (
  input  logic               clk,
  input  logic               reset,
  fp_round_pipe_if.slave     bus,
  input  logic               flags_clear,
  output logic               sticky_inexact,
  output logic               sticky_overflow
);
  localparam int unsigned ef_width = exp_width + frac_width;
  localparam logic [exp_width-1:0] exp_all_ones = '1;

  logic                  s1_valid;
  logic                  s1_sign;
  logic [exp_width-1:0]  s1_exp;
  logic [frac_width-1:0] s1_frac;
  logic                  s1_special;
  logic                  s1_round_up;
  logic                  s1_inexact;
  logic                  s1_adv;
  logic                  s2_adv;
  logic                  dec_round_up;

  logic                  out_valid_q;
  logic [ef_width:0]     out_result_q;
  fp_flags_t             out_flags_q;

  logic [ef_width-1:0]   sum;
  logic [ef_width:0]     s2_result;
  fp_flags_t             s2_flags;
  logic                  out_fire;

  // Each stage advances when empty or when its successor advances.
  assign s2_adv       = ~out_valid_q | bus.out_ready;
  assign s1_adv       = ~s1_valid | s2_adv;
  assign bus.in_ready = s1_adv;

  fp_round_decide u_decide (
    .mode     (bus.in_mode),
    .sign     (bus.in_sign),
    .lsb      (bus.in_frac[3]),
    .guard    (bus.in_frac[2]),
    .round    (bus.in_frac[1]),
    .sticky   (bus.in_frac[0]),
    .round_up (dec_round_up)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_sign     <= bus.in_sign;
        s1_exp      <= bus.in_exp;
        s1_frac     <= bus.in_frac[frac_width+2:3];
        s1_special  <= bus.in_special;
        s1_round_up <= dec_round_up;
        s1_inexact  <= |bus.in_frac[2:0];
      end
    end
  end

  // Single add over {exp, frac} lets a fraction carry ripple into the exponent.
  always_comb begin
    sum       = {s1_exp, s1_frac} + {{(ef_width-1){1'b0}}, s1_round_up};
    s2_result = {s1_sign, sum};
    s2_flags  = '{inexact: s1_inexact, overflow: 1'b0};
    if (s1_special) begin
      s2_result = {s1_sign, exp_all_ones, s1_frac};
      s2_flags  = '0;
    end else if (sum[ef_width-1 -: exp_width] == exp_all_ones) begin
      s2_result = {s1_sign, exp_all_ones, {frac_width{1'b0}}};
      s2_flags  = '{inexact: 1'b1, overflow: 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_flags_q  <= '0;
    end else if (s2_adv) begin
      out_valid_q <= s1_valid;
      if (s1_valid) begin
        out_result_q <= s2_result;
        out_flags_q  <= s2_flags;
      end
    end
  end

  assign bus.out_valid    = out_valid_q;
  assign bus.out_result   = out_result_q;
  assign bus.out_inexact  = out_flags_q.inexact;
  assign bus.out_overflow = out_flags_q.overflow;

  assign out_fire = out_valid_q & bus.out_ready;

  // A clear coinciding with a handshake keeps that handshake's flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      sticky_inexact  <= 1'b0;
      sticky_overflow <= 1'b0;
    end else begin
      sticky_inexact  <= (sticky_inexact  & ~flags_clear) | (out_fire & out_flags_q.inexact);
      sticky_overflow <= (sticky_overflow & ~flags_clear) | (out_fire & out_flags_q.overflow);
    end
  end
endmodule

// File: tb/tb_fp_round_pipe.sv
// Directed-vector bench for fp_round_pipe (exp_width=8, frac_width=23).
module tb_fp_round_pipe;
  logic clk = 1'b0;
  logic reset;
  logic flags_clear;
  logic sticky_inexact;
  logic sticky_overflow;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  fp_round_pipe_if #(.exp_width(8), .frac_width(23)) bus ();

  fp_round_pipe #(.exp_width(8), .frac_width(23)) dut (
    .clk             (clk),
    .reset           (reset),
    .bus             (bus),
    .flags_clear     (flags_clear),
    .sticky_inexact  (sticky_inexact),
    .sticky_overflow (sticky_overflow)
  );

  typedef struct {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
    logic [2:0]  grs;
    logic        special;
    logic [2:0]  mode;
    logic [31:0] result;
    logic        inexact;
    logic        overflow;
  } vec_t;

  vec_t vecs [17];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic drive(input vec_t v);
    bus.in_sign    = v.sign;
    bus.in_exp     = v.exp;
    bus.in_frac    = {v.frac, v.grs};
    bus.in_special = v.special;
    bus.in_mode    = v.mode;
  endtask

  // Presents one beat at a negedge and returns at the negedge where out_valid
  // is first seen, with the output not yet consumed.
  task automatic issue(input vec_t v, output int lat);
    drive(v);
    bus.in_valid = 1'b1;
    #1;
    check("in_ready_before_issue", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 10) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    vec_t v;
    logic [31:0] bp_exp [4];
    int sent, got, extra;
    bit saw_stall, stall_ok, fire_in;

    vecs[0]  = '{1'b0, 8'h7F, 23'h000000, 3'b100, 1'b0, 3'd0, 32'h3F800000, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 8'h7F, 23'h7FFFFF, 3'b100, 1'b0, 3'd0, 32'h40000000, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 8'h7F, 23'h7FFFFF, 3'b100, 1'b0, 3'd1, 32'h3FFFFFFF, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 8'hFE, 23'h7FFFFF, 3'b110, 1'b0, 3'd0, 32'h7F800000, 1'b1, 1'b1};
    vecs[4]  = '{1'b0, 8'hFE, 23'h7FFFFF, 3'b110, 1'b0, 3'd2, 32'h7F7FFFFF, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 8'hFF, 23'h400000, 3'b111, 1'b1, 3'd0, 32'h7FC00000, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 8'h7F, 23'h000001, 3'b100, 1'b0, 3'd0, 32'h3F800002, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 8'h7F, 23'h000001, 3'b000, 1'b0, 3'd3, 32'h3F800001, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 8'h7F, 23'h000000, 3'b001, 1'b0, 3'd3, 32'h3F800001, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 8'h7F, 23'h000000, 3'b001, 1'b0, 3'd3, 32'hBF800000, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 8'h7F, 23'h000000, 3'b001, 1'b0, 3'd2, 32'hBF800001, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 8'h7F, 23'h000000, 3'b100, 1'b0, 3'd4, 32'h3F800001, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 8'h7F, 23'h000000, 3'b110, 1'b0, 3'd7, 32'h3F800001, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 8'h7F, 23'h000000, 3'b100, 1'b0, 3'd5, 32'h3F800000, 1'b1, 1'b0};
    vecs[14] = '{1'b0, 8'h00, 23'h7FFFFF, 3'b111, 1'b0, 3'd0, 32'h00800000, 1'b1, 1'b0};
    vecs[15] = '{1'b1, 8'hFE, 23'h7FFFFF, 3'b100, 1'b0, 3'd0, 32'hFF800000, 1'b1, 1'b1};
    vecs[16] = '{1'b1, 8'hFE, 23'h7FFFFF, 3'b100, 1'b0, 3'd3, 32'hFF7FFFFF, 1'b1, 1'b0};

    reset = 1'b1;
    flags_clear = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    drive(vecs[0]);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", 64'(bus.out_valid), 64'd0);
    check("reset_out_result", 64'(bus.out_result), 64'd0);
    check("reset_out_flags", 64'({bus.out_inexact, bus.out_overflow}), 64'd0);
    check("reset_sticky", 64'({sticky_inexact, sticky_overflow}), 64'd0);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("post_reset_in_ready", 64'(bus.in_ready), 64'd1);

    foreach (vecs[i]) begin
      issue(vecs[i], lat);
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'd2);
      check($sformatf("vec%0d_result", i), 64'(bus.out_result), 64'(vecs[i].result));
      check($sformatf("vec%0d_inexact", i), 64'(bus.out_inexact), 64'(vecs[i].inexact));
      check($sformatf("vec%0d_overflow", i), 64'(bus.out_overflow), 64'(vecs[i].overflow));
      @(posedge clk);
      @(negedge clk);
    end

    // Back-pressure: out_ready low for cycles 2..4 while four beats stream in.
    do_reset();
    sent = 0; got = 0; extra = 0; saw_stall = 0; stall_ok = 1;
    for (int i = 0; i < 4; i++) bp_exp[i] = {1'b0, 8'(8'h80 + i), 23'(i)};
    for (int c = 0; c < 20; c++) begin
      bus.out_ready = !(c >= 2 && c <= 4);
      bus.in_valid  = (sent < 4);
      v = '{1'b0, 8'(8'h80 + sent), 23'(sent), 3'b000, 1'b0, 3'd1, 32'h0, 1'b0, 1'b0};
      drive(v);
      #1;
      if (!bus.in_ready) begin
        saw_stall = 1;
        if (sent - got != 2) stall_ok = 0;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (got < 4) check($sformatf("bp_beat%0d", got), 64'(bus.out_result), 64'(bp_exp[got]));
        else extra++;
        got++;
      end
      fire_in = bus.in_valid && bus.in_ready;
      @(posedge clk);
      if (fire_in) sent++;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    check("bp_stall_seen_at_two_pending", 64'({saw_stall, stall_ok}), 64'b11);
    check("bp_beats_out", 64'(got), 64'd4);
    check("bp_no_duplicates", 64'(extra), 64'd0);

    // Sticky flags.
    do_reset();
    issue(vecs[0], lat);
    @(posedge clk);
    @(negedge clk);
    check("sticky_after_inexact", 64'({sticky_inexact, sticky_overflow}), 64'b10);
    flags_clear = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flags_clear = 1'b0;
    check("sticky_plain_clear", 64'({sticky_inexact, sticky_overflow}), 64'b00);
    issue(vecs[0], lat);
    @(posedge clk);
    @(negedge clk);
    issue(vecs[7], lat);
    flags_clear = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flags_clear = 1'b0;
    check("sticky_clear_with_exact_beat", 64'({sticky_inexact, sticky_overflow}), 64'b00);
    issue(vecs[3], lat);
    flags_clear = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flags_clear = 1'b0;
    check("sticky_clear_with_overflow_beat", 64'({sticky_inexact, sticky_overflow}), 64'b11);

    // Reset with two beats in flight.
    drive(vecs[3]);
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    drive(vecs[1]);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midreset_out_valid", 64'(bus.out_valid), 64'd0);
    check("midreset_sticky", 64'({sticky_inexact, sticky_overflow}), 64'b00);
    check("midreset_in_ready", 64'(bus.in_ready), 64'd1);
    reset = 1'b0;
    extra = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.out_valid) extra++;
    end
    check("midreset_no_stale_output", 64'(extra), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
